signal_deglitch: RTL and testbench

Qualifies a raw asynchronous status/fault input (for example a driver desat or UVLO flag) before the pulse-extension stage. The input is optionally synchronised, then a change is accepted only after it persists for a programmable number of consecutive cycles. Each accepted change produces one single-cycle valid pulse plus the new level. This pulse/data pair drives the `i_vld` / `i_vld_data` inputs of `signal_extend` directly.

---
 rtl/pwr_sig_pkg.sv | 8 +
 rtl/sync_2ff.sv | 23 ++
 rtl/signal_deglitch.sv | 102 ++++++++++
 tb/tb_signal_deglitch.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pwr_sig_pkg.sv
// Shared types and defaults for the power-stage status signal qualifiers.
package pwr_sig_pkg;

  typedef enum logic {ST_STABLE, ST_FILT} deglitch_st_e;

  localparam int DEGLITCH_CYC_DEF = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both stages reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/signal_deglitch.sv
// Persistence filter for an async status/fault flag; emits a one-cycle valid/data pair per accepted edge.
// Define SIG_DEGLITCH_SYNC_EN to put i_sig through a 2-flop synchroniser first.
module signal_deglitch
  import pwr_sig_pkg::*;
#(
  parameter int   FILT_CYC_NUM = DEGLITCH_CYC_DEF,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  input  logic i_filt_en,
  output logic o_sig,
  output logic o_vld,
  output logic o_vld_data,
  output logic o_busy
);

  localparam int CNT_W = $clog2(FILT_CYC_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC_NUM - 1);

  logic s;

`ifdef SIG_DEGLITCH_SYNC_EN
  sync_2ff #(.RST_VAL(RST_VAL)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .d       (i_sig),
    .q       (s)
  );
`else
  assign s = i_sig;
`endif

  deglitch_st_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           lvl_q, vld_q, data_q;
  logic           commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s != lvl_q) begin
          if (i_filt_en) begin
            state_d = ST_FILT;
            cnt_d   = CNT_W'(1);
          end else begin
            commit  = 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_FILT: begin
        // Every exit from FILT clears the counter, so it can never wrap.
        if (!i_filt_en) begin
          commit  = (s != lvl_q);
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (s == lvl_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      lvl_q   <= RST_VAL;
      vld_q   <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= commit;
      data_q  <= commit & s;
      if (commit) lvl_q <= s;
    end
  end

  assign o_sig      = lvl_q;
  assign o_vld      = vld_q;
  assign o_vld_data = data_q;
  assign o_busy     = (state_q == ST_FILT);

endmodule

// File: tb/tb_signal_deglitch.sv
// Directed + randomized bench for signal_deglitch against a run-length reference model.
module tb_signal_deglitch;

  localparam int   N    = 4;
  localparam logic RVAL = 1'b0;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_sig = 1'b0;
  logic i_filt_en = 1'b1;
  logic o_sig, o_vld, o_vld_data, o_busy;

  signal_deglitch #(.FILT_CYC_NUM(N), .RST_VAL(RVAL)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sig      (i_sig),
    .i_filt_en  (i_filt_en),
    .o_sig      (o_sig),
    .o_vld      (o_vld),
    .o_vld_data (o_vld_data),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: level, pending run length of disagreeing samples, last-cycle outputs.
  logic m_lvl, m_vld, m_data, m_busy;
  int   run;
  logic sy1, sy2;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("o_sig", o_sig, m_lvl);
    chk("o_vld", o_vld, m_vld);
    chk("o_vld_data", o_vld_data, m_data);
    chk("o_busy", o_busy, m_busy);
  endtask

  task automatic model_reset();
    m_lvl = RVAL; m_vld = 1'b0; m_data = 1'b0; m_busy = 1'b0;
    run = 0; sy1 = RVAL; sy2 = RVAL;
  endtask

  // A new level is accepted once it has been seen N samples in a row
  // (or on first sight when filtering is off).
  task automatic step(input logic sig, input logic en);
    logic s;
    i_sig = sig;
    i_filt_en = en;
    @(posedge i_clk);
`ifdef SIG_DEGLITCH_SYNC_EN
    s = sy2; sy2 = sy1; sy1 = sig;
`else
    s = sig;
`endif
    m_vld = 1'b0;
    m_data = 1'b0;
    if (s != m_lvl) begin
      run = run + 1;
      if (!en || run == N) begin
        m_lvl = s; m_vld = 1'b1; m_data = s; run = 0;
      end
    end else begin
      run = 0;
    end
    m_busy = (run > 0);
    #1;
    check_all();
  endtask

  task automatic hold(input logic sig, input logic en, input int n);
    for (int k = 0; k < n; k++) step(sig, en);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();                       // reset state
    @(negedge i_clk);
    i_rst_n = 1'b1;

    hold(1'b0, 1'b1, 20);              // idle low
    hold(1'b1, 1'b1, N - 1);           // glitch of N-1 samples
    hold(1'b0, 1'b1, 6);
    hold(1'b1, 1'b1, 8);               // rising qualification
    hold(1'b0, 1'b1, 8);               // falling qualification
    for (int k = 0; k < 6; k++) hold(k[0] ? 1'b0 : 1'b1, 1'b0, 2);  // bypass toggling
    hold(1'b0, 1'b1, 6);

    hold(1'b1, 1'b1, 2);               // mid-FILT, then reset
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    hold(1'b1, 1'b1, 8);

    for (int it = 0; it < 250; it++) begin
      logic lv, en;
      int   len;
      lv  = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 9) != 0);
      len = $urandom_range(1, N + 3);
      hold(lv, en, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
